// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run/pause/clear sequencing, 1 Hz enable and expiry alarm for an mm:ss BCD countdown chain
module countdown_ctrl #(
    parameter int TICK_DIV    = 100000000,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    output logic       cnt_ce,
    output logic       cnt_load,
    output logic [1:0] state,
    output logic       running,
    output logic       alarm
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ALARM_TICKS + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, EXPIRED = 2'd3} state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [2:0]    hist_q, hist_d;
    logic          cnt_ce_q, cnt_ce_d, cnt_load_q, cnt_load_d;
    logic [2:0]    btns, edges;
    logic          zero, counting, tick, timeout;
    assign btns     = {btn_clear, btn_pause, btn_start};
    assign edges    = btns & ~hist_q;
    assign zero     = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0;
    assign counting = state_q == RUN || state_q == EXPIRED;
    assign tick     = counting && presc_q == PW'(TICK_DIV - 1);
    assign timeout  = tick && acnt_q == AW'(ALARM_TICKS - 1);
    always_comb begin
        state_d    = state_q;
        acnt_d     = acnt_q;
        cnt_ce_d   = 1'b0;
        cnt_load_d = 1'b0;
        hist_d     = btns;
        case (state_q)
            IDLE: begin
                cnt_load_d = edges[2];
                state_d    = (!edges[2] && edges[0] && !zero) ? RUN : IDLE;
            end
            RUN: begin
                state_d    = edges[2] ? IDLE : zero ? EXPIRED : |edges[1:0] ? PAUSE : RUN;
                cnt_load_d = edges[2];
                cnt_ce_d   = !edges[2] && !zero && !(|edges[1:0]) && tick;
            end
            PAUSE: begin
                state_d    = edges[2] ? IDLE : |edges[1:0] ? RUN : PAUSE;
                cnt_load_d = edges[2];
            end
            default: begin
                state_d    = (|edges || timeout) ? IDLE : EXPIRED;
                cnt_load_d = |edges || timeout;
                acnt_d     = (|edges || timeout) ? '0 : tick ? acnt_q + AW'(1) : acnt_q;
            end
        endcase
        presc_d = (state_d != state_q || !counting || tick) ? '0 : presc_q + PW'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            acnt_q     <= '0;
            hist_q     <= 3'b111;
            cnt_ce_q   <= 1'b0;
            cnt_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            acnt_q     <= acnt_d;
            hist_q     <= hist_d;
            cnt_ce_q   <= cnt_ce_d;
            cnt_load_q <= cnt_load_d;
        end
    end
    assign cnt_ce   = cnt_ce_q;
    assign cnt_load = cnt_load_q;
    assign state    = state_q;
    assign running  = state_q == RUN;
    assign alarm    = state_q == EXPIRED;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed scenarios with a BCD chain and an elapsed-time model compared every cycle
module tb_countdown_ctrl;
    localparam int TD = 4;
    localparam int AT = 3;
    logic       clk, reset, btn_start, btn_pause, btn_clear, set_zero;
    logic [3:0] d_mt, d_mo, d_st, d_so;
    logic       cnt_ce, cnt_load, running, alarm;
    logic [1:0] state;
    int         n_cmp = 0, n_err = 0;
    int         m_state, m_n;
    logic       m_ce, m_load;
    logic [2:0] m_prev;

    countdown_ctrl #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause), .btn_clear(btn_clear),
        .min_tens(d_mt), .min_ones(d_mo), .sec_tens(d_st), .sec_ones(d_so),
        .cnt_ce(cnt_ce), .cnt_load(cnt_load), .state(state), .running(running), .alarm(alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // digit chain with preset 00:02
    always @(posedge clk) begin
        if (reset || cnt_load) begin
            {d_mt, d_mo, d_st, d_so} <= 16'h0002;
        end else if (set_zero) begin
            {d_mt, d_mo, d_st, d_so} <= 16'h0000;
        end else if (cnt_ce) begin
            if (d_so != 0) d_so <= d_so - 4'd1;
            else begin
                d_so <= 4'd9;
                if (d_st != 0) d_st <= d_st - 4'd1;
                else begin
                    d_st <= 4'd5;
                    if (d_mo != 0) d_mo <= d_mo - 4'd1;
                    else begin
                        d_mo <= 4'd9;
                        d_mt <= d_mt - 4'd1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // model: m_n counts cycles spent in the current state; ticks fall on multiples of TD
    initial begin
        int  ns;
        logic [2:0] ed;
        logic z, tk;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_state = 0; m_n = 0; m_ce = 0; m_load = 0; m_prev = 3'b111;
            end else begin
                ed = {btn_clear, btn_pause, btn_start} & ~m_prev;
                m_prev = {btn_clear, btn_pause, btn_start};
                z  = {d_mt, d_mo, d_st, d_so} == 16'h0;
                tk = (m_state == 1 || m_state == 3) && (m_n % TD == TD - 1);
                ns = m_state; m_ce = 0; m_load = 0;
                if (m_state == 0) begin
                    if (ed[2]) m_load = 1;
                    else if (ed[0] && !z) ns = 1;
                end else if (m_state == 1) begin
                    if (ed[2]) begin ns = 0; m_load = 1; end
                    else if (z) ns = 3;
                    else if (ed[1:0] != 0) ns = 2;
                    else m_ce = tk;
                end else if (m_state == 2) begin
                    if (ed[2]) begin ns = 0; m_load = 1; end
                    else if (ed[1:0] != 0) ns = 1;
                end else if (ed != 0 || (tk && (m_n + 1) / TD == AT)) begin
                    ns = 0; m_load = 1;
                end
                m_n = (ns == m_state) ? m_n + 1 : 0;
                m_state = ns;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("state", int'(state), m_state);
            chk("cnt_ce", int'(cnt_ce), int'(m_ce));
            chk("cnt_load", int'(cnt_load), int'(m_load));
            chk("running", int'(running), int'(m_state == 1));
            chk("alarm", int'(alarm), int'(m_state == 3));
            chk("ce_load_excl", int'(cnt_ce & cnt_load), 0);
        end
    end

    initial begin
        reset = 1; btn_start = 1; btn_pause = 0; btn_clear = 0; set_zero = 0;
        step(3);
        chk("rst_state", int'(state), 0);
        chk("rst_ce", int'(cnt_ce), 0);
        chk("rst_load", int'(cnt_load), 0);
        chk("rst_alarm", int'(alarm), 0);
        reset = 0;
        step(2);
        chk("held_start", int'(state), 0);
        btn_start = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("post_rst_state", int'(state), 0);
            chk("post_rst_load", int'(cnt_load), 0);
        end
        // run from 00:02 to expiry
        btn_start = 1;
        step(1);
        btn_start = 0;
        for (int c = 0; c <= 10; c++) begin
            chk($sformatf("run_ce_c%0d", c), int'(cnt_ce), int'(c == 4 || c == 8));
            chk($sformatf("run_state_c%0d", c), int'(state), c < 10 ? 1 : 3);
            if (c == 9) chk("digits_zero", int'({d_mt, d_mo, d_st, d_so}), 0);
            if (c < 10) step(1);
        end
        chk("model_expired", m_state, 3);
        // alarm timeout after AT ticks
        for (int e = 0; e <= 12; e++) begin
            chk($sformatf("exp_state_e%0d", e), int'(state), e < 12 ? 3 : 0);
            chk($sformatf("exp_load_e%0d", e), int'(cnt_load), int'(e == 12));
            step(1);
        end
        chk("reload_digits", int'({d_mt, d_mo, d_st, d_so}), 2);
        chk("reload_load_off", int'(cnt_load), 0);
        // pause and resume
        btn_start = 1;
        step(1);
        btn_start = 0;
        step(2);
        btn_pause = 1;
        step(1);
        btn_pause = 0;
        chk("paused", int'(state), 2);
        chk("model_paused", m_state, 2);
        for (int i = 0; i < 10; i++) begin
            chk("pause_no_ce", int'(cnt_ce), 0);
            step(1);
        end
        chk("still_paused", int'(state), 2);
        btn_pause = 1;
        step(1);
        btn_pause = 0;
        for (int c = 0; c <= 4; c++) begin
            chk($sformatf("resume_ce_c%0d", c), int'(cnt_ce), int'(c == 4));
            if (c < 4) step(1);
        end
        for (int i = 0; i < 50 && state != 2'd3; i++) step(1);
        chk("expire_wait", int'(state), 3);
        // clear during alarm
        step(5);
        btn_clear = 1;
        step(1);
        chk("exp_clear_state", int'(state), 0);
        chk("exp_clear_load", int'(cnt_load), 1);
        chk("exp_clear_alarm", int'(alarm), 0);
        btn_clear = 0;
        step(1);
        chk("exp_clear_load_off", int'(cnt_load), 0);
        chk("exp_clear_digits", int'({d_mt, d_mo, d_st, d_so}), 2);
        // clear and start coinciding with a tick
        btn_start = 1;
        step(1);
        btn_start = 0;
        step(3);
        btn_clear = 1; btn_start = 1;
        step(1);
        chk("tick_clear_state", int'(state), 0);
        chk("tick_clear_load", int'(cnt_load), 1);
        chk("tick_clear_ce", int'(cnt_ce), 0);
        step(1);
        chk("tick_clear_load_off", int'(cnt_load), 0);
        chk("tick_clear_ce_off", int'(cnt_ce), 0);
        btn_clear = 0; btn_start = 0;
        step(1);
        // start at 00:00 is ignored, clear reloads
        set_zero = 1;
        step(1);
        set_zero = 0;
        btn_start = 1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("zero_start_state", int'(state), 0);
            chk("zero_start_ce", int'(cnt_ce), 0);
            chk("zero_start_load", int'(cnt_load), 0);
        end
        btn_start = 0;
        btn_clear = 1;
        step(1);
        chk("zero_clear_load", int'(cnt_load), 1);
        step(1);
        chk("zero_clear_load_off", int'(cnt_load), 0);
        btn_clear = 0;
        // reset mid-run
        btn_start = 1;
        step(1);
        btn_start = 0;
        chk("pre_reset_run", int'(state), 1);
        step(2);
        reset = 1;
        step(1);
        chk("midrst_state", int'(state), 0);
        chk("midrst_load", int'(cnt_load), 0);
        reset = 0;
        step(3);
        chk("midrst_idle", int'(state), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequencing controller for the mm:ss countdown digit chain (BCD down-counters: sec-ones mod-10, sec-tens mod-6, min-ones, min-tens).
- Generates the 1 Hz count-enable from the system clock and turns debounced start/pause/clear buttons into run/pause/clear control.
- Detects the 00:00 state, raises a timed alarm, and reloads the chain preset when the alarm is acknowledged or times out.
- Sits between the button debouncers and the digit-counter chain.

Parameters:
- TICK_DIV, 100000000, clk cycles per count tick (1 s at 100 MHz); must be >= 2.
- ALARM_TICKS, 10, number of ticks the alarm stays asserted before auto-return to IDLE; must be >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- btn_start  in  1  debounced level; rising edge = start/toggle.
- btn_pause  in  1  debounced level; rising edge = pause/resume.
- btn_clear  in  1  debounced level; rising edge = abort and reload.
- min_tens  in  4  BCD digit from chain.
- min_ones  in  4  BCD digit from chain.
- sec_tens  in  4  BCD digit from chain.
- sec_ones  in  4  BCD digit from chain.
- cnt_ce  out  1  registered 1-cycle pulse; chain decrements by one second.
- cnt_load  out  1  registered 1-cycle pulse; chain reloads its preset.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
- running  out  1  state==RUN.
- alarm  out  1  state==EXPIRED.

Behaviour:
- Reset state: state=IDLE; cnt_ce=0; cnt_load=0; prescaler=0; alarm tick count=0; button history registers=1. A button held through reset therefore produces no edge.
- Edge detect: edge = level & ~previous level; history updates every cycle.
- Priority when edges coincide: clear > start > pause.
- zero = all four digit inputs == 0, evaluated combinationally.
- Prescaler: counts 0..TICK_DIV-1 only in RUN and EXPIRED; tick when it equals TICK_DIV-1, then wraps to 0. It is forced to 0 on any state change and in IDLE/PAUSE.
  - RUN timing: let cycle 0 be the first cycle with state==RUN. Ticks occur at cycles TICK_DIV-1, 2*TICK_DIV-1, ...; cnt_ce is high the following cycle.
- IDLE:
  - clear edge: cnt_load pulse, stay in IDLE.
  - start edge with !zero: go to RUN.
  - start edge with zero: stay in IDLE, no output.
  - pause edge: ignored.
- RUN, evaluated in this order:
  1. clear edge: go to IDLE, cnt_load pulse.
  2. zero: go to EXPIRED.
  3. start or pause edge: go to PAUSE.
  4. tick: stay in RUN, cnt_ce pulse.
  - No cnt_ce is issued in a tick cycle that also leaves RUN.
  - Expiry is therefore registered the cycle after the digits first read 00:00; the chain never receives a CE at 00:00.
- PAUSE:
  - clear edge: go to IDLE, cnt_load pulse.
  - start or pause edge: go to RUN with the prescaler restarted from 0. The partial second is discarded by design.
- EXPIRED:
  - alarm=1. Each tick increments the alarm count.
  - Any button edge, or alarm count reaching ALARM_TICKS: go to IDLE with a cnt_load pulse; alarm count cleared.
- cnt_ce and cnt_load are never high in the same cycle. Each is high for exactly one cycle per event.
- reset mid-operation: immediate return to reset values on the next edge. No cnt_load is issued; the chain has its own reset.
- Digit inputs are not range-checked; non-BCD values count as nonzero.

Test Plan (TICK_DIV=4, ALARM_TICKS=3, behavioural BCD chain model with preset 00:02):
- Reset with btn_start held high, then release and hold low 5 cycles -> state=0, cnt_ce=0, cnt_load=0, alarm=0 throughout; no RUN entry.
- Start edge from 00:02 -> RUN; cnt_ce at RUN cycles 4 and 8; digits reach 00:00 at cycle 9; state=3, alarm=1 at cycle 10; no further cnt_ce.
- Start from 00:02, pause edge at RUN cycle 2 -> PAUSE, no cnt_ce for 10 cycles; pause edge again -> RUN; next cnt_ce exactly 4 cycles after re-entry.
- Let EXPIRED run -> after 3 ticks (12 cycles) state=0, one-cycle cnt_load, alarm=0; digits back to 00:02. Repeat with a clear edge at EXPIRED cycle 5 -> immediate IDLE plus cnt_load.
- In RUN, assert clear and start edges in the same cycle as a tick -> state=IDLE, cnt_load=1 for one cycle, cnt_ce stays 0.
- Chain at 00:00 in IDLE, start edge -> state stays 0, no cnt_ce, no cnt_load; clear edge -> single cnt_load pulse.
